// File: rtl/console_pkg.sv
// ---------------------------------------------------------------------------
// console_pkg
// Shared definitions for the console receive path: the encoding of the
// UART capture state machine, the "no byte pending" value that simpleuart
// returns on reg_dat_do, and the console baud divider.
// ---------------------------------------------------------------------------
package console_pkg;

    // Capture FSM states. SETTLE gives the UART a cycle to refresh reg_dat_do.
    typedef enum logic [1:0] {
        CAP_IDLE   = 2'd0,
        CAP_ACK    = 2'd1,
        CAP_SETTLE = 2'd2
    } cap_state_e;

    // simpleuart reg_dat_do reads as all ones when its receive buffer is empty.
    localparam logic [31:0] NO_DATA_DEFAULT = 32'hFFFF_FFFF;

    // 16 MHz system clock / 300 baud.
    localparam int unsigned CONSOLE_BAUD_DIV = 32'd53333;

endpackage

// File: rtl/console_byte_fifo.sv
// ---------------------------------------------------------------------------
// console_byte_fifo
// Synchronous byte FIFO with first-word-fall-through read port.
//   CLK    in   system clock
//   RST    in   synchronous active-high reset (pointers/count only)
//   PUSH   in   write WDATA this cycle (ignored when FULL)
//   POP    in   consume head byte this cycle (ignored when EMPTY)
//   WDATA  in   byte to write
//   RDATA  out  head byte, 8'h00 while EMPTY
//   COUNT  out  bytes held, 0 .. 2^DEPTH_LOG2
//   FULL   out  COUNT == 2^DEPTH_LOG2
//   EMPTY  out  COUNT == 0
// ---------------------------------------------------------------------------
module console_byte_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  PUSH,
    input  logic                  POP,
    input  logic [7:0]            WDATA,
    output logic [7:0]            RDATA,
    output logic [DEPTH_LOG2:0]   COUNT,
    output logic                  FULL,
    output logic                  EMPTY
);

    localparam int                    DEPTH       = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   DEPTH_COUNT = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE     = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE     = DEPTH_LOG2'(1);

    logic [7:0]            mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_r;
    logic [DEPTH_LOG2-1:0] rptr_r;
    logic [DEPTH_LOG2:0]   count_r;
    logic                  full_s;
    logic                  empty_s;
    logic                  push_ok_s;
    logic                  pop_ok_s;
    logic [7:0]            rdata_s;

    // Full/empty come from the pre-edge count, so a pop never makes room
    // for a push in the same cycle and a push never feeds a same-cycle pop.
    assign full_s    = (count_r == DEPTH_COUNT);
    assign empty_s   = (count_r == {(DEPTH_LOG2+1){1'b0}});
    assign push_ok_s = PUSH && !full_s;
    assign pop_ok_s  = POP && !empty_s;

    // Storage write; contents are deliberately not cleared by reset.
    always_ff @(posedge CLK) begin
        if (push_ok_s && !RST) begin
            mem_r[wptr_r] <= WDATA;
        end
    end

    // Pointer and occupancy update; pointers wrap naturally modulo depth.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr_r  <= {DEPTH_LOG2{1'b0}};
            rptr_r  <= {DEPTH_LOG2{1'b0}};
            count_r <= {(DEPTH_LOG2+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Fall-through head byte, forced to zero while nothing is held.
    always_comb begin
        rdata_s = 8'h00;
        if (!empty_s) begin
            rdata_s = mem_r[rptr_r];
        end else begin
            rdata_s = 8'h00;
        end
    end

    assign RDATA = rdata_s;
    assign COUNT = count_r;
    assign FULL  = full_s;
    assign EMPTY = empty_s;

endmodule

// File: rtl/console_rx_fifo.sv
// ---------------------------------------------------------------------------
// console_rx_fifo
// Drains the simpleuart receive register into a byte FIFO so the CPU's
// read-char instruction no longer races incoming characters.
//   CLK          in   system clock
//   RST          in   synchronous active-high reset
//   UART_DAT_DO  in   simpleuart reg_dat_do (byte in [7:0] unless NO_DATA)
//   UART_DAT_RE  out  registered one-cycle acknowledge to simpleuart
//   POP          in   CPU consumes the head byte
//   RDATA        out  {24'b0, head byte}, zero while EMPTY
//   EMPTY        out  no bytes held
//   FULL         out  2^DEPTH_LOG2 bytes held
//   COUNT        out  bytes held
//   OVERRUN      out  sticky flag: a byte was dropped on a full FIFO
//   CLR_OVERRUN  in   clears OVERRUN (a same-cycle drop wins)
// ---------------------------------------------------------------------------
module console_rx_fifo
    import console_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 4,
    parameter logic [31:0] NO_DATA    = NO_DATA_DEFAULT
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [31:0]         UART_DAT_DO,
    output logic                UART_DAT_RE,
    input  logic                POP,
    output logic [31:0]         RDATA,
    output logic                EMPTY,
    output logic                FULL,
    output logic [DEPTH_LOG2:0] COUNT,
    output logic                OVERRUN,
    input  logic                CLR_OVERRUN
);

    cap_state_e state_r;
    cap_state_e next_state_s;
    logic       byte_valid_s;
    logic       push_s;
    logic       drop_s;
    logic       re_next_s;
    logic       re_r;
    logic       overrun_r;
    logic       fifo_full_s;
    logic [7:0] fifo_rdata_s;

    assign byte_valid_s = (UART_DAT_DO != NO_DATA);

    // Capture state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= CAP_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Capture next-state logic: one sample, one acknowledge, one settle cycle.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            CAP_IDLE: begin
                if (byte_valid_s) begin
                    next_state_s = CAP_ACK;
                end else begin
                    next_state_s = CAP_IDLE;
                end
            end
            CAP_ACK:    next_state_s = CAP_SETTLE;
            CAP_SETTLE: next_state_s = CAP_IDLE;
            default:    next_state_s = CAP_IDLE;
        endcase
    end

    // Capture output decode: a sampled byte is always acknowledged, and is
    // either stored or dropped depending on the pre-edge FULL.
    always_comb begin
        push_s    = 1'b0;
        drop_s    = 1'b0;
        re_next_s = 1'b0;
        if ((state_r == CAP_IDLE) && byte_valid_s) begin
            re_next_s = 1'b1;
            push_s    = !fifo_full_s;
            drop_s    = fifo_full_s;
        end else begin
            re_next_s = 1'b0;
            push_s    = 1'b0;
            drop_s    = 1'b0;
        end
    end

    // Acknowledge pulse and sticky overrun flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            re_r      <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            re_r <= re_next_s;
            if (drop_s) begin
                overrun_r <= 1'b1;
            end else if (CLR_OVERRUN) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    console_byte_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .PUSH  (push_s),
        .POP   (POP),
        .WDATA (UART_DAT_DO[7:0]),
        .RDATA (fifo_rdata_s),
        .COUNT (COUNT),
        .FULL  (fifo_full_s),
        .EMPTY (EMPTY)
    );

    assign UART_DAT_RE = re_r;
    assign OVERRUN     = overrun_r;
    assign FULL        = fifo_full_s;
    assign RDATA       = {24'h000000, fifo_rdata_s};

endmodule
